// File: rtl/shared_ram_arb_pkg.sv
// shared_ram_arb_pkg: shared types, default widths and round-robin index helper
package shared_ram_arb_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/shared_ram_arbiter_if.sv
// shared_ram_arbiter_if: requester-side and RAM-side signals of the shared RAM arbiter
interface shared_ram_arbiter_if import shared_ram_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) ();
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic                ram_en;
  logic                ram_we;
  logic                ram_re;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic [DW-1:0]       ram_rdata;
  modport slave (
    input  req, we, addr, wdata, ram_rdata,
    output gnt, rvalid, rdata, ram_en, ram_we, ram_re, ram_addr, ram_wdata
  );
  modport master (
    output req, we, addr, wdata, ram_rdata,
    input  gnt, rvalid, rdata, ram_en, ram_we, ram_re, ram_addr, ram_wdata
  );
endinterface

// File: rtl/shared_ram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting just after ptr
module rr_picker import shared_ram_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] j;
  assign any = |req;
  // Scan farthest-first so the slot right after ptr overwrites and wins.
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'(rr_idx(int'(ptr), k, N_REQ));
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: round-robin sharing of one synchronous single-port RAM
module shared_ram_arbiter import shared_ram_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input logic                  clk,
  input logic                  rst_n,
  shared_ram_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_nx;
  logic [IW-1:0] ptr, win, idx;
  logic any, take;
  logic [N_REQ-1:0] gnt_r, rvalid_r;
  logic [DW-1:0] rdata_r, ram_wdata_r;
  logic [AW-1:0] ram_addr_r;
  logic ram_en_r, ram_we_r, ram_re_r;
  rr_picker #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .ptr(ptr), .idx(win), .any(any));
  // ram_we_r is only consulted in ACCESS, where it still holds the captured write flag.
  always_comb begin
    take = (state == IDLE) && any;
    state_nx = (state == IDLE) ? (any ? ACCESS : IDLE) :
               (state == ACCESS && !ram_we_r) ? READ_WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= IW'(N_REQ - 1);
      idx <= '0;
      gnt_r <= '0;
      rvalid_r <= '0;
      rdata_r <= '0;
      ram_en_r <= 1'b0;
      ram_we_r <= 1'b0;
      ram_re_r <= 1'b0;
      ram_addr_r <= '0;
      ram_wdata_r <= '0;
    end else begin
      state <= state_nx;
      gnt_r <= '0;
      rvalid_r <= '0;
      ram_en_r <= 1'b0;
      ram_we_r <= 1'b0;
      ram_re_r <= 1'b0;
      if (take) begin
        idx <= win;
        ptr <= win;
        gnt_r <= N_REQ'(1) << win;
        ram_en_r <= 1'b1;
        ram_we_r <= bus.we[win];
        ram_re_r <= !bus.we[win];
        ram_addr_r <= bus.addr[win*AW +: AW];
        ram_wdata_r <= bus.wdata[win*DW +: DW];
      end
      if (state == READ_WAIT) begin
        rdata_r <= bus.ram_rdata;
        rvalid_r <= N_REQ'(1) << idx;
      end
    end
  end
  assign bus.gnt       = gnt_r;
  assign bus.rvalid    = rvalid_r;
  assign bus.rdata     = rdata_r;
  assign bus.ram_en    = ram_en_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_re    = ram_re_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Round-robin arbiter that shares one synchronous single-port 8-bit RAM among up to N_REQ peripheral requesters (mouse, keyboard, display, CPU port). Each requester raises a request carrying address, write flag and write data. The arbiter serialises the requests onto the RAM's enable/read/write strobes and returns read data with a per-requester valid pulse. It sits between the peripheral blocks and the shared RAM in the SoC interconnect.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- AW, 8, address width
- DW, 8, data width

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester access request; held high until matching gnt seen
- we  in  N_REQ  per-requester write flag (1 write, 0 read); valid while req high
- addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- wdata  in  N_REQ*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- rvalid  out  N_REQ  one-hot, one-cycle read-data-valid pulse
- rdata  out  DW  read data, valid when any rvalid bit high
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered inside RAM (valid the cycle after ram_re)

## Operation
- FSM states: IDLE, ACCESS, READ_WAIT.
- IDLE: if any req bit is set, select a winner by round-robin. Search starts at ptr+1 and wraps modulo N_REQ.
  - On the edge: capture the winner's index, we, addr and wdata into command registers. Set ptr to the winner index. Go to ACCESS.
  - If no req bit is set, stay in IDLE.
- ACCESS (one cycle):
  - ram_en=1, ram_we=cmd_we, ram_re=~cmd_we; ram_addr and ram_wdata come from the command registers.
  - gnt[idx]=1.
  - Next state: IDLE for a write, READ_WAIT for a read.
- READ_WAIT (one cycle): ram_en, ram_we and ram_re are all 0. On the edge, rdata<=ram_rdata and rvalid[idx]<=1, so rvalid is visible in the following cycle. Next state: IDLE.
- rvalid pulses for exactly one cycle. rdata holds its last value until the next read completes.
- All outputs are registered; there is no combinational path from req to gnt or ram_*.
- Reset values: gnt=0, rvalid=0, rdata=0, ram_en=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, state=IDLE, ptr=N_REQ-1 (requester 0 wins first).
- Boundary conditions:
  - **All requesters active:** grants rotate 0,1,2,3,0… and no requester waits more than N_REQ-1 grants.
  - **Single requester:** it is re-granted immediately once it re-requests.
  - **Request dropped without a grant:** this is a protocol violation. A request already captured still executes and its gnt still pulses.
  - **New request from the requester just granted:** it is treated as a new request with the normal round-robin position.
  - **Reset mid-access:** all outputs clear asynchronously, the access is aborted, and no rvalid is issued. A RAM write cycle interrupted by reset is not guaranteed.
  - **Reading an address written by the immediately preceding access:** returns the new data, as RAM write completes before the next ACCESS.

## Timing
- Cycle 0 is the first IDLE cycle with req high.
- Write: gnt and RAM strobes in cycle 1; RAM written at the end of cycle 1. Throughput is one write per 2 cycles.
- Read: gnt and ram_re in cycle 1; ram_rdata valid in cycle 2; rvalid and rdata in cycle 3. Back-to-back reads complete every 3 cycles.
  - IDLE arbitration in cycle 3 overlaps the rvalid pulse, so the next gnt appears in cycle 4.
- Requesters are registered. They sample gnt at the end of cycle 1 and drop or refresh req by cycle 2, when the arbiter is in IDLE again.

## Structure
- Package shared_ram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, READ_WAIT);
  - default AW/DW constants;
  - a function for the next round-robin index.
- Sub-module rr_picker: purely combinational. Inputs are req and ptr; outputs are a winner index and an any-request flag.
- The top level contains the FSM, the command registers, ptr, and the output registers.

## Test plan
- Reset: assert rst_n=0 mid-ACCESS -> all outputs 0 immediately. After release, a single req[2] write gets gnt[2] as requester 0 priority starts at ptr=3.
- Write then read same requester: req[0] writes addr 0x10 / data 0xA5, then reads 0x10 -> gnt[0] in cycle 1 (ram_we=1, addr 0x10, wdata 0xA5). The read returns rvalid[0]=1, rdata=0xA5 exactly 3 cycles after its request.
- Fairness: req=4'b1111 held continuously, all writes -> gnt sequence 0,1,2,3,0,1, one grant every 2 cycles.
- Mixed contention: req[1] read 0x20 (RAM holds 0x3C) and req[3] write 0x20/0x77 raised together, ptr=0 -> requester 1 is granted first and rvalid[1] returns 0x3C. Then requester 3's write lands; a subsequent read returns 0x77.
- Idle stability: req=0 for 20 cycles -> gnt, rvalid and ram_en remain 0, and ptr is unchanged.
- Parameter sweep: N_REQ=2 and N_REQ=8 with all requests active -> grants rotate through every index with wrap-around back to 0.
